// File: rtl/keypad_pkg.sv
// Shared constants, scan-result/FSM encodings and the keypad position-to-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Rows 0-2 hold digits 1-9 in reading order; the bottom row is '*', 0, '#'.
    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_snap_decode.sv
// Classifies a 12-bit scan snapshot (bit = col*4 + row) as none, single key or multi-key.
module keypad_snap_decode
    import keypad_pkg::*;
(
    input  logic [11:0] snap,
    output scan_res_t   kind,
    output logic [3:0]  code
);

    logic [3:0] ones;
    logic [3:0] found;

    always_comb begin
        ones  = '0;
        found = KEY_NONE;
        for (int unsigned i = 0; i < 12; i++) begin
            if (snap[i]) begin
                ones  = ones + 4'd1;
                found = key_code_of(2'(i % 4), 2'(i / 4));
            end
        end

        kind = RES_NONE;
        code = KEY_NONE;
        if (ones == 4'd1) begin
            kind = RES_SINGLE;
            code = found;
        end else if (ones != 4'd0) begin
            kind = RES_MULTI;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row snapshot, debounce FSM and one pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 2,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [2:0]  col_out,
    output logic [11:0] key_onehot,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam int unsigned TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [3:0]    DB_LAST   = 4'(DEBOUNCE_SCANS);

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [11:0]   snap_q, snap_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [11:0]   key_onehot_q, key_onehot_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          tick_last;
    logic          scan_end;
    logic          emit;
    logic [3:0]    emit_code;
    logic [11:0]   eval_snap;
    scan_res_t     res_kind;
    logic [3:0]    res_code;

    // Column 2 rows are evaluated live so the decision uses this scan's final slice.
    assign eval_snap = {row_in, snap_q[7:0]};

    keypad_snap_decode u_decode (
        .snap (eval_snap),
        .kind (res_kind),
        .code (res_code)
    );

    always_comb begin
        tick_last = (tick_q == TICK_LAST);
        scan_end  = tick_last && (col_idx_q == 2'd2);

        tick_d    = tick_last ? '0 : tick_q + 1'b1;
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        if (tick_last) begin
            col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
            case (col_idx_q)
                2'd0:    snap_d[3:0]  = row_in;
                2'd1:    snap_d[7:4]  = row_in;
                default: snap_d[11:8] = row_in;
            endcase
        end

        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = cand_q;

        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_kind == RES_SINGLE) begin
                        cand_d = res_code;
                        cnt_d  = 4'd1;
                        if (DB_LAST == 4'd1) begin
                            state_d   = ST_PRESSED;
                            emit      = 1'b1;
                            emit_code = res_code;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (res_kind == RES_SINGLE && res_code == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DB_LAST) begin
                            state_d = ST_PRESSED;
                            emit    = 1'b1;
                        end
                    end else if (res_kind == RES_SINGLE) begin
                        cand_d = res_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (res_kind == RES_NONE) begin
                        cnt_d   = 4'd1;
                        state_d = (DB_LAST == 4'd1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin
                    if (res_kind == RES_NONE) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DB_LAST) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
            endcase
        end

        key_valid_d  = emit;
        key_onehot_d = emit ? (12'h001 << emit_code) : '0;
        key_code_d   = emit ? emit_code : key_code_q;
        key_held_d   = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q       <= '0;
            col_idx_q    <= '0;
            snap_q       <= '0;
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            cnt_q        <= '0;
            key_onehot_q <= '0;
            key_code_q   <= KEY_NONE;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            col_idx_q    <= col_idx_d;
            snap_q       <= snap_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            key_onehot_q <= key_onehot_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign col_out    = 3'b001 << col_idx_q;
    assign key_onehot = key_onehot_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model on the row lines, vector table plus corner-case sequences.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  row_in;
    logic [2:0]  col_out;
    logic [11:0] key_onehot;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [11:0] keys;      // bit index = key code currently held on the pad
    int          cyc;
    int          checks;
    int          failures;
    int          total_pulses;
    int          held_low_cnt;
    int          bad_out_cnt;
    logic [11:0] last_onehot;

    keypad_scanner #(
        .SCAN_TICKS     (2),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_onehot (key_onehot),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int code_at(input int r, input int c);
        case (r)
            0: return c + 1;
            1: return c + 4;
            2: return c + 7;
            default: return (c == 0) ? 11 : ((c == 1) ? 0 : 10);
        endcase
    endfunction

    always_comb begin
        row_in = '0;
        for (int c = 0; c < 3; c++)
            if (col_out[c])
                for (int r = 0; r < 4; r++)
                    if (keys[code_at(r, c)]) row_in[r] = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                total_pulses <= total_pulses + 1;
                last_onehot  <= key_onehot;
            end
            if (!key_held) held_low_cnt <= held_low_cnt + 1;
            if ((key_valid && (key_onehot != (12'h001 << key_code))) ||
                (!key_valid && key_onehot != 12'h000) ||
                !(col_out == 3'b001 || col_out == 3'b010 || col_out == 3'b100))
                bad_out_cnt <= bad_out_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic run_scans(input int n);
        repeat (6 * n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    typedef struct {
        logic [11:0] keys;
        int          scans;
        int          exp_pulses;
        logic [11:0] exp_onehot;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[8];
    int   base;
    int   hbase;

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        total_pulses = 0; held_low_cnt = 0; bad_out_cnt = 0;
        last_onehot = '0;
        cyc = 0;
        rst = 1'b1;

        vecs[0] = '{12'h004, 4, 1, 12'h004, 4'd2};
        vecs[1] = '{12'h400, 4, 1, 12'h400, 4'd10};
        vecs[2] = '{12'h800, 4, 1, 12'h800, 4'd11};
        vecs[3] = '{12'h001, 4, 1, 12'h001, 4'd0};
        vecs[4] = '{12'h200, 4, 1, 12'h200, 4'd9};
        vecs[5] = '{12'h048, 6, 0, 12'h000, 4'd9};
        vecs[6] = '{12'h020, 2, 0, 12'h000, 4'd9};
        vecs[7] = '{12'h100, 3, 1, 12'h100, 4'd8};

        // Reset values and '2' held from the first scan
        keys = 12'h004;
        do_reset();
        check("rst_col_out", 32'(col_out), 32'h1);
        check("rst_key_code", 32'(key_code), 32'hf);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_onehot", 32'(key_onehot), 32'h0);
        base = total_pulses;
        step_to(17);
        check("t1_no_early_pulse", 32'(key_valid), 32'h0);
        step_to(18);
        check("t1_valid", 32'(key_valid), 32'h1);
        check("t1_onehot", 32'(key_onehot), 32'h004);
        check("t1_code", 32'(key_code), 32'h2);
        check("t1_held", 32'(key_held), 32'h1);
        step_to(19);
        check("t1_valid_drop", 32'(key_valid), 32'h0);
        step_to(30);
        check("t1_one_pulse", 32'(total_pulses - base), 32'h1);
        keys = 12'h000;
        step_to(47);
        check("t1_held_before_release", 32'(key_held), 32'h1);
        step_to(48);
        check("t1_held_released", 32'(key_held), 32'h0);

        // Glitching '5': one scan on, one scan off
        do_reset();
        base = total_pulses;
        for (int i = 0; i < 5; i++) begin
            keys = 12'h020; run_scans(1);
            keys = 12'h000; run_scans(1);
        end
        check("t3_glitch_pulses", 32'(total_pulses - base), 32'h0);
        check("t3_glitch_code", 32'(key_code), 32'hf);

        // '1'+'9' together, then '9' released
        base = total_pulses;
        keys = 12'h202;
        run_scans(10);
        check("t4_multi_pulses", 32'(total_pulses - base), 32'h0);
        keys = 12'h002;
        run_scans(2);
        check("t4_not_yet", 32'(key_valid), 32'h0);
        run_scans(1);
        check("t4_valid", 32'(key_valid), 32'h1);
        check("t4_onehot", 32'(key_onehot), 32'h002);
        check("t4_code", 32'(key_code), 32'h1);
        keys = 12'h000;
        run_scans(5);
        check("t4_pulses", 32'(total_pulses - base), 32'h1);

        // '7': long hold, short release re-press, full release re-press
        base = total_pulses;
        keys = 12'h080;
        run_scans(50);
        check("t5_long_hold", 32'(total_pulses - base), 32'h1);
        hbase = held_low_cnt;
        keys = 12'h000; run_scans(2);
        keys = 12'h080; run_scans(5);
        check("t5_short_gap_pulses", 32'(total_pulses - base), 32'h1);
        check("t5_held_throughout", 32'(held_low_cnt - hbase), 32'h0);
        keys = 12'h000; run_scans(3);
        check("t5_released", 32'(key_held), 32'h0);
        keys = 12'h080; run_scans(4);
        check("t5_second_pulse", 32'(total_pulses - base), 32'h2);
        check("t5_code", 32'(key_code), 32'h7);
        keys = 12'h000; run_scans(5);

        foreach (vecs[i]) begin
            base = total_pulses;
            keys = vecs[i].keys;
            run_scans(vecs[i].scans);
            keys = 12'h000;
            run_scans(5);
            check($sformatf("vec%0d_pulses", i), 32'(total_pulses - base), 32'(vecs[i].exp_pulses));
            check($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].exp_code));
            if (vecs[i].exp_pulses > 0)
                check($sformatf("vec%0d_onehot", i), 32'(last_onehot), 32'(vecs[i].exp_onehot));
            check($sformatf("vec%0d_held", i), 32'(key_held), 32'h0);
        end

        // Reset one cycle before the accepting scan-end of '2'
        keys = 12'h004;
        do_reset();
        base = total_pulses;
        step_to(16);
        rst = 1'b1;
        keys = 12'h000;
        step();
        check("t6_col_out", 32'(col_out), 32'h1);
        check("t6_code", 32'(key_code), 32'hf);
        check("t6_held", 32'(key_held), 32'h0);
        step();
        rst = 1'b0;
        check("t6_valid", 32'(key_valid), 32'h0);
        repeat (30) step();
        check("t6_no_pulse", 32'(total_pulses - base), 32'h0);
        check("t6_code_after", 32'(key_code), 32'hf);

        check("output_consistency", 32'(bad_out_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
